// File: rtl/ifetch.sv
// Instruction-fetch unit for the multi-cycle MIPS core.
// Owns the PC, issues valid/ready instruction requests, holds the fetched
// word for decode until commit, then selects the next PC (jump > taken
// branch > sequential).
// Optional feature macro: IFETCH_ALIGN_CHECK_EN -- traps a misaligned
// next PC into a sticky ERR state that raises fetch_err.
module ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        Inst_Req_Valid,
   input  logic        Inst_Req_Ready,
   input  logic        Inst_Valid,
   output logic        Inst_Ready,
   input  logic [31:0] Inst_Rdata,
   output logic [31:0] PC,
   output logic [31:0] Instruction,
   output logic        id_valid,
   input  logic        commit,
   input  logic        Branch,
   input  logic        branch_taken,
   input  logic        Jump,
   input  logic [31:0] Branch_addr,
   input  logic [31:0] Jump_addr,
   output logic [31:0] inst_cnt,
   output logic        fetch_err
);

   typedef enum logic [2:0] {
      ST_RST = 3'd0,
      ST_IF  = 3'd1,
      ST_IW  = 3'd2,
      ST_ID  = 3'd3,
      ST_ERR = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;

   // Redirect target: jump wins over a taken branch; branch offset is PC+4 relative
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      next_pc  = pc_plus4;
      if (Jump)
         next_pc = Jump_addr;
      else if (Branch && branch_taken)
         next_pc = pc_plus4 + Branch_addr;
   end

   // Next-state and datapath update; inputs outside their owning state are ignored
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RST: state_d = ST_IF;
         ST_IF: begin
            if (Inst_Req_Ready)
               state_d = ST_IW;
         end
         ST_IW: begin
            if (Inst_Valid) begin
               instr_d = Inst_Rdata;
               state_d = ST_ID;
            end
         end
         ST_ID: begin
            if (commit) begin
               pc_d    = next_pc;
               cnt_d   = cnt_q + 32'd1;
               state_d = ST_IF;
`ifdef IFETCH_ALIGN_CHECK_EN
               if (next_pc[1:0] != 2'b00)
                  state_d = ST_ERR;
`endif
            end
         end
         // ERR is sticky until reset
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_RST;
      endcase
   end

   // State and datapath registers; async reset drops handshakes immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RST;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         cnt_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode from state/registers only, no input-to-output paths
   assign Inst_Req_Valid = (state_q == ST_IF);
   assign Inst_Ready     = (state_q == ST_IW);
   assign id_valid       = (state_q == ST_ID);
   assign PC             = pc_q;
   assign Instruction    = instr_q;
   assign inst_cnt       = cnt_q;
`ifdef IFETCH_ALIGN_CHECK_EN
   assign fetch_err      = (state_q == ST_ERR);
`else
   assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, zero-wait and stalled fetch, sequential,
// branch and jump redirects, PC wrap, misaligned target, reset mid-handshake.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        Inst_Req_Valid, Inst_Req_Ready, Inst_Valid, Inst_Ready;
   logic [31:0] Inst_Rdata, PC, Instruction, Branch_addr, Jump_addr, inst_cnt;
   logic        id_valid, commit, Branch, branch_taken, Jump, fetch_err;

   int vectors = 0;
   int miscompares = 0;

   ifetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
      .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst_Rdata(Inst_Rdata),
      .PC(PC), .Instruction(Instruction), .id_valid(id_valid),
      .commit(commit), .Branch(Branch), .branch_taken(branch_taken), .Jump(Jump),
      .Branch_addr(Branch_addr), .Jump_addr(Jump_addr),
      .inst_cnt(inst_cnt), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Zero-wait fetch from IF: one cycle in IF, one in IW, then ID
   task automatic fetch(input logic [31:0] w);
      Inst_Req_Ready = 1'b1; Inst_Valid = 1'b1; Inst_Rdata = w;
      tick();
      chk("fetch_iw", {31'h0, Inst_Ready}, 32'h1);
      tick();
      chk("fetch_idv", {31'h0, id_valid}, 32'h1);
      chk("fetch_instr", Instruction, w);
      Inst_Req_Ready = 1'b0; Inst_Valid = 1'b0;
   endtask

   task automatic do_commit(input logic j, input logic [31:0] ja, input logic b,
                            input logic bt, input logic [31:0] ba,
                            input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
      Jump = j; Jump_addr = ja; Branch = b; branch_taken = bt; Branch_addr = ba;
      commit = 1'b1;
      tick();
      commit = 1'b0; Jump = 1'b0; Branch = 1'b0; branch_taken = 1'b0;
      chk("commit_reqv", {31'h0, Inst_Req_Valid}, 32'h1);
      chk("commit_pc", PC, exp_pc);
      chk("commit_cnt", inst_cnt, exp_cnt);
   endtask

   initial begin
      rst_n = 1'b0; Inst_Req_Ready = 1'b0; Inst_Valid = 1'b0; Inst_Rdata = 32'h0;
      commit = 1'b0; Branch = 1'b0; branch_taken = 1'b0; Jump = 1'b0;
      Branch_addr = 32'h0; Jump_addr = 32'h0;
      tick(); tick();
      chk("rst_reqv", {31'h0, Inst_Req_Valid}, 32'h0);
      chk("rst_ready", {31'h0, Inst_Ready}, 32'h0);
      chk("rst_idv", {31'h0, id_valid}, 32'h0);
      chk("rst_err", {31'h0, fetch_err}, 32'h0);
      chk("rst_pc", PC, 32'h0);
      chk("rst_instr", Instruction, 32'h0);
      chk("rst_cnt", inst_cnt, 32'h0);

      // Release reset: first edge enters IF with PC=RESET_PC
      rst_n = 1'b1;
      tick();
      chk("if_reqv", {31'h0, Inst_Req_Valid}, 32'h1);
      chk("if_pc", PC, 32'h0);
      fetch(32'h2000_0001);

      // Three sequential commits
      do_commit(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4, 32'd1);
      fetch(32'h2000_0002);
      do_commit(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h8, 32'd2);
      fetch(32'h2000_0003);
      do_commit(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hC, 32'd3);

      // Stalled memory: 3 extra IF cycles with stray commit / Inst_Valid ignored
      for (int i = 0; i < 3; i++) begin
         commit = 1'b1; Inst_Valid = 1'b1; Inst_Rdata = 32'hDEAD_BEEF;
         tick();
         chk("stall_if_reqv", {31'h0, Inst_Req_Valid}, 32'h1);
         chk("stall_if_pc", PC, 32'hC);
         chk("stall_if_cnt", inst_cnt, 32'd3);
         chk("stall_if_instr", Instruction, 32'h2000_0003);
      end
      commit = 1'b0; Inst_Valid = 1'b0; Inst_Req_Ready = 1'b1;
      tick();
      Inst_Req_Ready = 1'b0;
      chk("stall_iw_ready", {31'h0, Inst_Ready}, 32'h1);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("stall_iw_hold", {31'h0, Inst_Ready}, 32'h1);
         chk("stall_iw_idv", {31'h0, id_valid}, 32'h0);
         chk("stall_iw_pc", PC, 32'hC);
      end
      Inst_Valid = 1'b1; Inst_Rdata = 32'h1234_5678;
      tick();
      Inst_Valid = 1'b0;
      chk("stall_idv_7", {31'h0, id_valid}, 32'h1);
      chk("stall_instr", Instruction, 32'h1234_5678);

      // Branch taken / not taken around PC=0x100
      do_commit(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h100, 32'd4);
      fetch(32'h1000_FFFC);
      do_commit(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'hF4, 32'd5);
      fetch(32'h0);
      do_commit(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h100, 32'd6);
      fetch(32'h1000_FFFC);
      do_commit(1'b0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h104, 32'd7);
      fetch(32'h0);
      // branch_taken without Branch is ignored
      do_commit(1'b0, 32'h0, 1'b0, 1'b1, 32'h1000, 32'h108, 32'd8);

      // Jump wins over a simultaneous taken branch
      fetch(32'h0);
      do_commit(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h40, 32'd9);
      fetch(32'h0800_0000);
      do_commit(1'b1, 32'h0040_0000, 1'b1, 1'b1, 32'h10, 32'h0040_0000, 32'd10);

      // Sequential wrap from the top of the address space
      fetch(32'h0);
      do_commit(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'd11);
      fetch(32'h0);
      do_commit(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'd12);

      // Misaligned jump target
      fetch(32'h0);
      Jump = 1'b1; Jump_addr = 32'h102; commit = 1'b1;
      tick();
      Jump = 1'b0; commit = 1'b0;
      chk("mis_pc", PC, 32'h102);
      chk("mis_cnt", inst_cnt, 32'd13);
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("mis_err", {31'h0, fetch_err}, 32'h1);
      chk("mis_reqv", {31'h0, Inst_Req_Valid}, 32'h0);
      Inst_Req_Ready = 1'b1; Inst_Valid = 1'b1;
      tick(); tick();
      chk("err_sticky", {31'h0, fetch_err}, 32'h1);
      chk("err_noreq", {31'h0, Inst_Req_Valid}, 32'h0);
      chk("err_idv", {31'h0, id_valid}, 32'h0);
      Inst_Req_Ready = 1'b0; Inst_Valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("err_rst_clear", {31'h0, fetch_err}, 32'h0);
      rst_n = 1'b1;
      tick();
`else
      chk("mis_err", {31'h0, fetch_err}, 32'h0);
      chk("mis_reqv", {31'h0, Inst_Req_Valid}, 32'h1);
`endif

      // Reset pulse while waiting in IW abandons the pending response
      Inst_Req_Ready = 1'b1;
      tick();
      Inst_Req_Ready = 1'b0;
      chk("iw_before_rst", {31'h0, Inst_Ready}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_iw_ready", {31'h0, Inst_Ready}, 32'h0);
      chk("rst_iw_pc", PC, 32'h0);
      chk("rst_iw_cnt", inst_cnt, 32'h0);
      chk("rst_iw_instr", Instruction, 32'h0);
      tick();
      rst_n = 1'b1;
      Inst_Valid = 1'b1; Inst_Rdata = 32'hCAFE_F00D;
      tick();
      chk("restart_reqv", {31'h0, Inst_Req_Valid}, 32'h1);
      chk("restart_pc", PC, 32'h0);
      tick();
      chk("restart_hold", {31'h0, Inst_Req_Valid}, 32'h1);
      chk("restart_instr", Instruction, 32'h0);
      Inst_Valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch unit for the multi-cycle MIPS core. It owns the program counter and issues instruction requests over the valid/ready instruction-memory handshake. It presents the fetched word and its PC to the decoder and holds them until the core commits. On commit it selects the next PC from the decoder's branch/jump outputs.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Inst_Req_Valid  out  1  fetch request valid; request address is PC.
- Inst_Req_Ready  in  1  memory accepts the request.
- Inst_Valid  in  1  Inst_Rdata carries the requested word.
- Inst_Ready  out  1  ifetch accepts a returned word.
- Inst_Rdata  in  32  returned instruction word.
- PC  out  32  address of the current instruction; feeds the decoder and the memory request.
- Instruction  out  32  registered instruction word to the decoder.
- id_valid  out  1  PC/Instruction hold a decodable instruction.
- commit  in  1  core finished the current instruction; redirect inputs are sampled this cycle.
- Branch  in  1  current instruction is a conditional branch.
- branch_taken  in  1  branch condition true.
- Jump  in  1  current instruction is J/JAL/JR/JALR.
- Branch_addr  in  32  sign-extended byte offset (offset<<2), relative to PC+4.
- Jump_addr  in  32  absolute jump target.
- inst_cnt  out  32  committed-instruction counter.
- fetch_err  out  1  misaligned target trap (see Configuration).

## Operation
- FSM states: RST, IF, IW, ID, ERR.
- RST:
  - Entered asynchronously while rst_n=0.
  - Reset values: PC=RESET_PC, Instruction=0, inst_cnt=0.
  - Reset values: Inst_Req_Valid=0, Inst_Ready=0, id_valid=0, fetch_err=0.
  - Goes to IF on the first clock edge with rst_n=1.
- IF: Inst_Req_Valid=1 with PC stable. On Inst_Req_Valid & Inst_Req_Ready, go to IW.
- IW: Inst_Ready=1. On Inst_Valid & Inst_Ready, Instruction<=Inst_Rdata and go to ID.
- ID:
  - id_valid=1; PC and Instruction hold.
  - On commit: PC<=next_pc, inst_cnt<=inst_cnt+1, go to IF.
- next_pc priority:
  - Jump: Jump_addr.
  - else Branch & branch_taken: PC+4+Branch_addr.
  - else: PC+4.
- All additions are 32-bit modulo 2^32. PC=32'hFFFF_FFFC sequential wraps to 0.
- inst_cnt wraps from 32'hFFFF_FFFF to 0.
- branch_taken is ignored when Branch=0.
- commit outside ID is ignored: no PC, counter, or state change.
- Inst_Valid outside IW is ignored, and Instruction is unchanged.
- Inst_Req_Ready outside IF is ignored.
- No branch delay slot: the instruction at the target is the next instruction fetched.

## Timing
- Zero-wait memory (Inst_Req_Ready and Inst_Valid high the cycle they are first sampled): IF 1 cycle, IW 1 cycle. id_valid rises 2 cycles after entering IF.
- Each memory wait cycle adds one cycle in the corresponding state.
- Commit to next request: Inst_Req_Valid is high in the cycle after the commit edge, with PC=next_pc.
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths.
- Reset mid-handshake:
  - Inst_Req_Valid and Inst_Ready drop immediately (asynchronously).
  - Any pending memory response is abandoned.
  - Fetch restarts at RESET_PC.

## Configuration
- IFETCH_ALIGN_CHECK_EN defined:
  - On commit in ID, if next_pc[1:0]!=0, PC<=next_pc, inst_cnt increments, and the FSM goes to ERR.
  - ERR asserts fetch_err=1 and holds all other outputs at their ERR values: Inst_Req_Valid=0, id_valid=0.
  - ERR is left only by reset.
- IFETCH_ALIGN_CHECK_EN undefined:
  - fetch_err is tied to 0 and ERR is unreachable.
  - Misaligned next_pc is fetched as-is.

## Test plan
- Reset with RESET_PC=0, release rst_n, zero-wait memory → Inst_Req_Valid=1 with PC=0 in the first cycle. id_valid=1 with Instruction=Inst_Rdata two cycles later.
- Three sequential commits, Jump=Branch=0 → PC sequence 0,4,8,12 and inst_cnt=3.
- Inst_Req_Ready delayed 3 cycles and Inst_Valid delayed 2 cycles → PC stable throughout. id_valid rises 7 cycles after entering IF.
- PC=0x100, Branch=1, branch_taken=1, Branch_addr=0xFFFF_FFF0 → next request at 0xF4. Same with branch_taken=0 → 0x104.
- PC=0x40, Jump=1, Jump_addr=0x0040_0000, Branch=1, branch_taken=1 simultaneously → next PC=0x0040_0000 (jump wins).
- Jump_addr=0x102:
  - Macro on: fetch_err=1, no further requests.
  - Macro off: request issued at 0x102.
  - Both builds: rst_n pulse while in IW clears to PC=RESET_PC.
